// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory timeout and halt.
// Optional feature macro CTRL_TRAP_EN: illegal opcodes take a one-cycle TRAP to the trap vector.
module multicycle_control #(
  parameter int OPC_W   = 4,
  parameter int ALUOP_W = 2,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               cond_true,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               byte_en,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               r15_write,
  output logic               halted,
  output logic               bus_err
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
`ifdef CTRL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef enum logic [3:0] {
    C_TYPEA, C_ANDI, C_ORI, C_LBU, C_SB, C_LW, C_SW, C_BR, C_JMP, C_HALT, C_ILL
  } class_t;

  typedef struct packed {
    logic       memReq;
    logic       memWe;
    logic       iord;
    logic       byteEn;
    logic       aluSrc;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       regWrite;
    logic       memToReg;
    logic       r15Write;
    logic       halted;
  } ctrl_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            stateReg, stateNext;
  class_t            classReg, classNext;
  logic [CNT_W-1:0]  cntReg, cntNext;
  logic              busErrReg, timeoutHit;
  ctrl_t             ctrlReg;

  function automatic class_t decode(input logic [OPC_W-1:0] op);
    if ((op >> 4) != '0) return C_ILL;
    case (op[3:0])
      4'b1111: return C_TYPEA;
      4'b1000: return C_ANDI;
      4'b1001: return C_ORI;
      4'b1010: return C_LBU;
      4'b1011: return C_SB;
      4'b1100: return C_LW;
      4'b1101: return C_SW;
      4'b0100, 4'b0101, 4'b0110: return C_BR;
      4'b0001: return C_JMP;
      4'b0000: return C_HALT;
      default: return C_ILL;
    endcase
  endfunction

  // State-determined outputs for the state about to be entered; registered below.
  function automatic ctrl_t ctrlFor(input state_t s, input class_t c);
    ctrl_t o;
    o = '0;
    case (s)
      S_FETCH: o.memReq = 1'b1;
      S_EXEC: begin
        o.aluSrc = (c != C_TYPEA);
        case (c)
          C_TYPEA, C_ANDI: o.aluOp = 2'b11;
          C_ORI:           o.aluOp = 2'b10;
          C_BR:  begin o.aluOp = 2'b01; o.pcSrc = 2'b01; end
          C_JMP: o.pcSrc = 2'b10;
          default:         o.aluOp = 2'b00;
        endcase
      end
      S_MEM: begin
        o.memReq = 1'b1;
        o.iord   = 1'b1;
        o.memWe  = (c == C_SB) || (c == C_SW);
        o.byteEn = (c == C_LBU) || (c == C_SB);
      end
      S_WB: begin
        o.regWrite = 1'b1;
        o.memToReg = (c == C_LW) || (c == C_LBU);
        o.r15Write = (c == C_TYPEA);
      end
      S_HALT: o.halted = 1'b1;
`ifdef CTRL_TRAP_EN
      S_TRAP: o.pcSrc = 2'b11;
`endif
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    stateNext  = stateReg;
    classNext  = classReg;
    timeoutHit = 1'b0;
    case (stateReg)
      S_FETCH, S_MEM: begin
        // memReq is low only in the first cycle after reset release.
        if (ctrlReg.memReq) begin
          if (mem_ready) begin
            if (stateReg == S_FETCH)                         stateNext = S_DECODE;
            else if (classReg == C_SB || classReg == C_SW)   stateNext = S_FETCH;
            else                                             stateNext = S_WB;
          end else if (cntReg == CNT_LAST) begin
            stateNext  = S_HALT;
            timeoutHit = 1'b1;
          end
        end
      end
      S_DECODE: begin
        classNext = decode(opcode);
        case (classNext)
          C_HALT: stateNext = S_HALT;
`ifdef CTRL_TRAP_EN
          C_ILL:  stateNext = S_TRAP;
`else
          C_ILL:  stateNext = S_FETCH;
`endif
          default: stateNext = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (classReg)
          C_LBU, C_SB, C_LW, C_SW: stateNext = S_MEM;
          C_BR, C_JMP:             stateNext = S_FETCH;
          default:                 stateNext = S_WB;
        endcase
      end
      S_WB:   stateNext = S_FETCH;
      S_HALT: stateNext = S_HALT;
      default: stateNext = S_FETCH;
    endcase

    cntNext = '0;
    if (ctrlReg.memReq && !mem_ready && stateNext == stateReg)
      cntNext = cntReg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= S_FETCH;
      classReg  <= C_ILL;
      cntReg    <= '0;
      busErrReg <= 1'b0;
      ctrlReg   <= '0;
    end else begin
      stateReg <= stateNext;
      classReg <= classNext;
      cntReg   <= cntNext;
      if (timeoutHit) busErrReg <= 1'b1;
      ctrlReg  <= ctrlFor(stateNext, classNext);
    end
  end

  // Handshake- and flag-dependent strobes must act in the same cycle as their input.
  assign ir_write = (stateReg == S_FETCH) && ctrlReg.memReq && mem_ready;
`ifdef CTRL_TRAP_EN
  assign pc_write = ir_write || (stateReg == S_TRAP) ||
                    ((stateReg == S_EXEC) && ((classReg == C_BR && cond_true) || classReg == C_JMP));
`else
  assign pc_write = ir_write ||
                    ((stateReg == S_EXEC) && ((classReg == C_BR && cond_true) || classReg == C_JMP));
`endif

  assign mem_req    = ctrlReg.memReq;
  assign mem_we     = ctrlReg.memWe;
  assign iord       = ctrlReg.iord;
  assign byte_en    = ctrlReg.byteEn;
  assign pc_src     = ctrlReg.pcSrc;
  assign alu_src    = ctrlReg.aluSrc;
  assign alu_op     = ALUOP_W'(ctrlReg.aluOp);
  assign reg_write  = ctrlReg.regWrite;
  assign mem_to_reg = ctrlReg.memToReg;
  assign r15_write  = ctrlReg.r15Write;
  assign halted     = ctrlReg.halted;
  assign bus_err    = busErrReg;

endmodule
